// File: rtl/stream_arb_mux_if.sv
// -----------------------------------------------------------------------------
// stream_arb_mux_if
// Bundle of the packet-stream signals around stream_arb_mux.
//   Input side : in_data (CHANNELS*WIDTH, channel i at [i*WIDTH +: WIDTH]),
//                in_valid, in_last (CHANNELS), in_ready (CHANNELS, from mux)
//   Output side: out_data (WIDTH), out_valid, out_last, out_sel (source channel),
//                out_ready (from downstream)
// modport master : the environment that feeds inputs and consumes the output.
// modport slave  : the mux itself.
// -----------------------------------------------------------------------------
interface stream_arb_mux_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_last;
    logic [CHANNELS-1:0]       in_ready;

    logic [WIDTH-1:0]          out_data;
    logic                      out_valid;
    logic                      out_last;
    logic [SEL_W-1:0]          out_sel;
    logic                      out_ready;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_sel
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, out_sel
    );
endinterface

// File: rtl/stream_arb_mux.sv
// -----------------------------------------------------------------------------
// stream_arb_mux
// Packet-aware N:1 stream multiplexer with a single output register.
// A channel wins arbitration on its first beat and keeps the grant until its
// last beat is accepted. Arbitration is round-robin (RR=1) or fixed priority,
// lowest index first (RR=0).
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high; abandons any packet in flight
//   bus   - stream_arb_mux_if.slave: in_data/in_valid/in_last/in_ready per
//           channel, out_data/out_valid/out_last/out_sel/out_ready
// -----------------------------------------------------------------------------
module stream_arb_mux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int RR       = 1
) (
    input  logic            clk,
    input  logic            reset,
    stream_arb_mux_if.slave bus
);
    localparam int SEL_W = $clog2(CHANNELS);

    typedef enum logic {ARB, LOCKED} state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    lock_q, lock_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;

    logic [2*CHANNELS-1:0] valid_rot;
    logic [SEL_W:0]      pick_sum;
    logic [SEL_W-1:0]    arb_pick;
    logic                arb_found;
    logic [SEL_W-1:0]    grant;
    logic                can_load;
    logic [CHANNELS-1:0] ready;
    logic                accept;
    logic [WIDTH-1:0]    sel_data;
    logic                sel_last;

    logic [WIDTH-1:0]    data_q;
    logic                valid_q;
    logic                last_q;
    logic [SEL_W-1:0]    sel_q;

    // Rotate the valids so bit 0 is the channel at the priority pointer, then
    // take the lowest set bit; scanning downward lets the nearest one win.
    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        valid_rot = {bus.in_valid, bus.in_valid} >> ptr_q;
        arb_pick  = '0;
        arb_found = 1'b0;
        pick_sum  = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (valid_rot[k]) begin
                pick_sum = {1'b0, ptr_q} + (SEL_W + 1)'(k);
                if (pick_sum >= (SEL_W + 1)'(CHANNELS)) begin
                    pick_sum = pick_sum - (SEL_W + 1)'(CHANNELS);
                end
                arb_pick  = pick_sum[SEL_W-1:0];
                arb_found = 1'b1;
            end
        end
    end

    // A locked channel keeps the grant even while its valid is low, so the
    // output simply waits for the rest of the packet.
    assign grant    = (state_q == LOCKED) ? lock_q : arb_pick;
    assign can_load = !valid_q || bus.out_ready;

    always_comb begin
        ready = '0;
        if (!reset && can_load && ((state_q == LOCKED) || arb_found)) begin
            ready[grant] = 1'b1;
        end
    end

    assign accept = |(ready & bus.in_valid);

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant == SEL_W'(i)) begin
                sel_data = bus.in_data[i*WIDTH +: WIDTH];
                sel_last = bus.in_last[i];
            end
        end
    end

    // Packet tracking: lock on a non-last beat, release and advance the
    // pointer (round-robin only) once the last beat goes through.
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        ptr_d   = ptr_q;
        if (accept) begin
            if (sel_last) begin
                state_d = ARB;
                if (RR != 0) begin
                    ptr_d = (grant == SEL_W'(CHANNELS - 1)) ? '0 : grant + 1'b1;
                end
            end else begin
                state_d = LOCKED;
                lock_d  = grant;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB;
            lock_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            ptr_q   <= ptr_d;
        end
    end

    // NOTE: the datapath register is reset as well, so out_data/out_sel never
    // expose a value left over from before reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            sel_q   <= '0;
        end else if (accept) begin
            valid_q <= 1'b1;
            data_q  <= sel_data;
            last_q  <= sel_last;
            sel_q   <= grant;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.out_last  = last_q;
    assign bus.out_sel   = sel_q;
endmodule

// File: tb/tb_stream_arb_mux.sv
// -----------------------------------------------------------------------------
// tb_stream_arb_mux
// Drives one shared stimulus into a round-robin mux (dut_rr) and a fixed
// priority mux (dut_fp). A packet-level reference model predicts in_ready and
// the output register of each every cycle; directed literal checks pin the
// headline scenarios.
// -----------------------------------------------------------------------------
module tb_stream_arb_mux;
    logic        clk;
    logic        reset;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_last;
    logic        out_ready;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    // Reference model, index 0 = round-robin, 1 = fixed priority.
    int         m_owner [2];   // channel owning an open packet, -1 when none
    int         m_ptr   [2];
    logic       m_ov    [2];
    logic [7:0] m_od    [2];
    logic       m_ol    [2];
    int         m_os    [2];

    stream_arb_mux_if #(.WIDTH(8), .CHANNELS(4)) if_rr ();
    stream_arb_mux_if #(.WIDTH(8), .CHANNELS(4)) if_fp ();

    assign if_rr.in_data   = in_data;
    assign if_rr.in_valid  = in_valid;
    assign if_rr.in_last   = in_last;
    assign if_rr.out_ready = out_ready;
    assign if_fp.in_data   = in_data;
    assign if_fp.in_valid  = in_valid;
    assign if_fp.in_last   = in_last;
    assign if_fp.out_ready = out_ready;

    stream_arb_mux #(.WIDTH(8), .CHANNELS(4), .RR(1)) dut_rr (
        .clk   (clk),
        .reset (reset),
        .bus   (if_rr.slave)
    );

    stream_arb_mux #(.WIDTH(8), .CHANNELS(4), .RR(0)) dut_fp (
        .clk   (clk),
        .reset (reset),
        .bus   (if_fp.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear(input int d);
        m_owner[d] = -1;
        m_ptr[d]   = 0;
        m_ov[d]    = 1'b0;
        m_od[d]    = 8'h00;
        m_ol[d]    = 1'b0;
        m_os[d]    = 0;
    endtask

    // Compare one DUT against the model, then advance the model by one clock.
    task automatic model_cycle(input int d, input logic [3:0] a_rdy, input logic a_ov,
                               input logic [7:0] a_od, input logic a_ol, input logic [1:0] a_os);
        int         g;
        int         c;
        logic       load_ok;
        logic [3:0] e_rdy;
        string      tag;
        tag     = (d == 0) ? "rr" : "fp";
        load_ok = !m_ov[d] || out_ready;
        g       = -1;
        if (m_owner[d] >= 0) begin
            g = m_owner[d];
        end else begin
            for (int k = 3; k >= 0; k--) begin
                c = (m_ptr[d] + k) % 4;
                if (in_valid[c[1:0]]) g = c;
            end
        end
        e_rdy = 4'b0000;
        if (!reset && load_ok && g >= 0) e_rdy[g[1:0]] = 1'b1;

        check({tag, "_in_ready"},  {28'd0, a_rdy}, {28'd0, e_rdy});
        check({tag, "_out_valid"}, {31'd0, a_ov},  {31'd0, m_ov[d]});
        check({tag, "_out_data"},  {24'd0, a_od},  {24'd0, m_od[d]});
        check({tag, "_out_last"},  {31'd0, a_ol},  {31'd0, m_ol[d]});
        check({tag, "_out_sel"},   {30'd0, a_os},  32'(m_os[d]));

        if (reset) begin
            model_clear(d);
        end else if (e_rdy != 4'b0000 && in_valid[g[1:0]]) begin
            m_ov[d] = 1'b1;
            m_od[d] = in_data[g*8 +: 8];
            m_ol[d] = in_last[g[1:0]];
            m_os[d] = g;
            if (in_last[g[1:0]]) begin
                m_owner[d] = -1;
                if (d == 0) m_ptr[d] = (g + 1) % 4;
            end else begin
                m_owner[d] = g;
            end
        end else if (out_ready) begin
            m_ov[d] = 1'b0;
        end
    endtask

    // Inputs change at posedge+1, so the negative edge sees them settled.
    always @(negedge clk) begin
        if (chk_en) begin
            model_cycle(0, if_rr.in_ready, if_rr.out_valid, if_rr.out_data, if_rr.out_last, if_rr.out_sel);
            model_cycle(1, if_fp.in_ready, if_fp.out_valid, if_fp.out_data, if_fp.out_last, if_fp.out_sel);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic v, input logic l, input logic [7:0] d);
        in_valid[ch]       = v;
        in_last[ch]        = l;
        in_data[ch*8 +: 8] = d;
    endtask

    task automatic expect_rr(input string name, input logic ov, input logic [7:0] od,
                             input logic ol, input logic [1:0] os);
        check({name, "_valid"}, {31'd0, if_rr.out_valid}, {31'd0, ov});
        check({name, "_data"},  {24'd0, if_rr.out_data},  {24'd0, od});
        check({name, "_last"},  {31'd0, if_rr.out_last},  {31'd0, ol});
        check({name, "_sel"},   {30'd0, if_rr.out_sel},   {30'd0, os});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear(0);
        model_clear(1);
        reset     = 1'b1;
        in_data   = '0;
        in_valid  = '0;
        in_last   = '0;
        out_ready = 1'b0;

        // Reset state.
        tick();
        chk_en = 1;
        tick();
        reset = 1'b0;
        expect_rr("reset", 1'b0, 8'h00, 1'b0, 2'd0);
        check("reset_in_ready", {28'd0, if_rr.in_ready}, 32'h0);

        // Single beat on channel 2.
        out_ready = 1'b1;
        set_ch(2, 1'b1, 1'b1, 8'hA5);
        #1;
        check("single_in_ready", {28'd0, if_rr.in_ready}, 32'h4);
        tick();
        set_ch(2, 1'b0, 1'b0, 8'h00);
        expect_rr("single", 1'b1, 8'hA5, 1'b1, 2'd2);
        tick();
        check("single_drain", {31'd0, if_rr.out_valid}, 32'h0);

        // Round-robin fairness: reset the pointer, then all channels stream.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int ch = 0; ch < 4; ch++) set_ch(ch, 1'b1, 1'b1, 8'(8'h40 + ch));
        for (int i = 0; i < 8; i++) begin
            tick();
            expect_rr("rr_fair", 1'b1, 8'(8'h40 + (i % 4)), 1'b1, 2'(i % 4));
            check("fp_fair_sel", {30'd0, if_fp.out_sel}, 32'h0);
        end
        in_valid = '0;
        tick();

        // Lock: channel 1 packet 0x11,0x12,0x13 while channel 0 waits.
        set_ch(1, 1'b1, 1'b0, 8'h11);
        tick();
        expect_rr("lock_b0", 1'b1, 8'h11, 1'b0, 2'd1);
        set_ch(0, 1'b1, 1'b1, 8'h0A);
        set_ch(1, 1'b1, 1'b0, 8'h12);
        tick();
        expect_rr("lock_b1", 1'b1, 8'h12, 1'b0, 2'd1);
        set_ch(1, 1'b0, 1'b0, 8'h12);
        tick();
        check("lock_gap_valid", {31'd0, if_rr.out_valid}, 32'h0);
        set_ch(1, 1'b1, 1'b1, 8'h13);
        tick();
        expect_rr("lock_b2", 1'b1, 8'h13, 1'b1, 2'd1);
        set_ch(1, 1'b0, 1'b0, 8'h00);
        tick();
        expect_rr("lock_next", 1'b1, 8'h0A, 1'b1, 2'd0);
        set_ch(0, 1'b0, 1'b0, 8'h00);
        tick();

        // Backpressure on channel 3.
        set_ch(3, 1'b1, 1'b1, 8'h80);
        tick();
        expect_rr("bp_first", 1'b1, 8'h80, 1'b1, 2'd3);
        out_ready = 1'b0;
        set_ch(3, 1'b1, 1'b1, 8'h81);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_in_ready", {28'd0, if_rr.in_ready}, 32'h0);
            tick();
            expect_rr("bp_hold", 1'b1, 8'h80, 1'b1, 2'd3);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {28'd0, if_rr.in_ready}, 32'h8);
        tick();
        expect_rr("bp_resume1", 1'b1, 8'h81, 1'b1, 2'd3);
        set_ch(3, 1'b1, 1'b1, 8'h82);
        tick();
        expect_rr("bp_resume2", 1'b1, 8'h82, 1'b1, 2'd3);
        set_ch(3, 1'b0, 1'b0, 8'h00);
        tick();

        // Fixed priority: channel 0 beats channel 3 until it goes idle.
        set_ch(0, 1'b1, 1'b1, 8'h01);
        set_ch(3, 1'b1, 1'b1, 8'h03);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("fp_prio_sel", {30'd0, if_fp.out_sel}, 32'h0);
        end
        set_ch(0, 1'b0, 1'b0, 8'h00);
        tick();
        check("fp_after_sel", {30'd0, if_fp.out_sel}, 32'h3);
        check("fp_after_data", {24'd0, if_fp.out_data}, 32'h03);
        set_ch(3, 1'b0, 1'b0, 8'h00);
        tick();

        // Reset in the middle of a channel 2 packet.
        set_ch(2, 1'b1, 1'b0, 8'h21);
        tick();
        expect_rr("rst_b0", 1'b1, 8'h21, 1'b0, 2'd2);
        set_ch(2, 1'b1, 1'b0, 8'h22);
        reset = 1'b1;
        #1;
        check("rst_in_ready", {28'd0, if_rr.in_ready}, 32'h0);
        tick();
        reset = 1'b0;
        expect_rr("rst_cleared", 1'b0, 8'h00, 1'b0, 2'd0);
        set_ch(2, 1'b0, 1'b0, 8'h00);
        set_ch(0, 1'b1, 1'b1, 8'h05);
        #1;
        check("rst_new_ready", {28'd0, if_rr.in_ready}, 32'h1);
        tick();
        expect_rr("rst_new_beat", 1'b1, 8'h05, 1'b1, 2'd0);
        set_ch(0, 1'b0, 1'b0, 8'h00);
        tick();
        tick();

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/stream_arb_mux.md
STREAM_ARB_MUX -- requirements
Module: stream_arb_mux

Interface
REQ-001 Parameter WIDTH, default 8, data bits per channel.
REQ-002 Parameter CHANNELS, default 4, number of input channels (2..16).
REQ-003 Parameter RR, default 1: 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 in_valid  input  CHANNELS  per-channel beat valid.
REQ-009 in_last  input  CHANNELS  per-channel end-of-packet marker.
REQ-010 in_ready  output  CHANNELS  per-channel beat accepted when valid and ready are both high.
REQ-011 out_data  output  WIDTH  registered selected beat.
REQ-012 out_valid  output  1  out_data holds an unconsumed beat.
REQ-013 out_last  output  1  registered copy of accepted beat's last.
REQ-014 out_sel  output  $clog2(CHANNELS)  source channel of the beat in the output register.
REQ-015 out_ready  input  1  downstream accepts the beat when out_valid and out_ready are both high.

Function
REQ-016 Output stage SHALL be one register; can_load = !out_valid || out_ready.
REQ-017 in_ready[i] SHALL be combinational: high only for i == grant and only while can_load; all other bits low.
REQ-018 On in_valid[g] && in_ready[g], next cycle: out_data = in_data[g], out_last = in_last[g], out_sel = g, out_valid = 1. Latency is exactly 1 cycle.
REQ-019 If out_ready && out_valid and no input is accepted in the same cycle, out_valid SHALL clear next cycle; out_data/out_last/out_sel hold.
REQ-020 Simultaneous output consume and input accept SHALL sustain one beat per cycle with no bubble.
REQ-021 FSM states: ARB, LOCKED. Reset state is ARB.
REQ-022 In ARB, grant = highest-priority channel with in_valid high. With no valid channel, no in_ready is asserted.
REQ-023 ARB -> LOCKED when an accepted beat has in_last = 0; the locked channel is the granted channel.
REQ-024 In LOCKED, grant SHALL equal the locked channel regardless of other valids. LOCKED -> ARB when that channel's beat with in_last = 1 is accepted.
REQ-025 A single beat with in_last = 1 accepted in ARB SHALL be a whole packet; the FSM stays in ARB.
REQ-026 RR = 1: the priority pointer p starts at 0. After a last beat from channel k is accepted, p = (k+1) mod CHANNELS, wrapping from CHANNELS-1 to 0. Search order is p, p+1, ..., wrapping.
REQ-027 RR = 0: p SHALL remain 0 permanently.
REQ-028 Grant SHALL only change at packet boundaries. A channel dropping in_valid mid-packet SHALL NOT release the lock; the output waits.
REQ-029 When out_ready is low and out_valid is high, all in_ready SHALL be low and the output register SHALL hold stable.

Reset
REQ-030 Reset SHALL set out_valid = 0, out_data = 0, out_last = 0, out_sel = 0, FSM = ARB, p = 0.
REQ-031 Reset asserted mid-packet SHALL abandon the packet: lock cleared, the buffered beat dropped, all in_ready low during reset.
REQ-032 No output SHALL depend on state not cleared by reset.

Verification
REQ-033 Single channel: channel 2 sends 0xA5 (last = 1), out_ready = 1 -> next cycle out_valid = 1, out_data = 0xA5, out_sel = 2, out_last = 1.
REQ-034 Round-robin fairness: RR = 1, all 4 channels continuously sending 1-beat packets -> out_sel sequence 0,1,2,3,0,... with one beat per cycle.
REQ-035 Lock: channel 1 sends a 3-beat packet 0x11, 0x12, 0x13 while channel 0 is valid -> out_data 0x11, 0x12, 0x13 from out_sel = 1 consecutively, then channel 0 is granted.
REQ-036 Backpressure: out_ready held low 5 cycles with out_valid = 1 -> out_data stable, in_ready = 0000; out_ready high -> transfer resumes with no beat lost or duplicated.
REQ-037 Fixed priority: RR = 0, channels 0 and 3 both valid with 1-beat packets -> channel 0 always granted; channel 3 is granted only after channel 0 deasserts valid.
REQ-038 Reset mid-packet: reset asserted after beat 1 of a 3-beat packet on channel 2 -> out_valid = 0 and FSM in ARB next cycle; a subsequent channel 0 beat is granted normally.
